// File: rtl/fir10_response_checker.sv
// fir10_response_checker
// Response monitor for the 10-tap symmetric constant-coefficient FIR.
// It recomputes the expected output from the input stream, delays it by
// LATENCY cycles, and compares it word for word with the filter output.
// It reports per-cycle mismatches, saturating counters and the first
// failing pair.
module fir10_response_checker #(
    parameter int LATENCY = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [11:0] In_X,
    input  logic        [28:0] Out_Y,
    output logic               mismatch,
    output logic        [15:0] err_count,
    output logic        [15:0] chk_count,
    output logic        [28:0] first_exp,
    output logic        [28:0] first_got,
    output logic               first_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2
    } state_t;

    // The warm-up counter holds this value on the last WARMUP cycle.
    // The first comparison then lands LATENCY+10 edges after enable rises.
    localparam logic [6:0] WARM_LAST = 7'(LATENCY + 8);

    state_t            state_q, state_d;
    logic [6:0]        wcnt_q, wcnt_d;
    logic signed [11:0] hist [10];
    logic signed [12:0] pair [5];
    logic signed [28:0] w    [5];
    logic [28:0]       exp_now;
    logic [28:0]       exp_cmp;
    logic              do_cmp;
    logic              differs;

    // Input history: x(t) in hist[0] down to x(t-9) in hist[9].
    always_ff @(posedge clk) begin
        // NOTE: this short line is reset explicitly, because the warm-up
        // length assumes that every tap starts at zero.
        if (rst) begin
            for (int i = 0; i < 10; i++) hist[i] <= '0;
        end else begin
            // NOTE: use non-blocking assignments so that every tap reads its
            // neighbour's value from before this clock edge.
            hist[0] <= In_X;
            for (int i = 1; i < 10; i++) hist[i] <= hist[i-1];
        end
    end

    // Golden model: add the symmetric taps in pairs, then form each
    // constant product from shift-add terms, all modulo 2^29.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pair[i] = {hist[i][11], hist[i]} + {hist[9-i][11], hist[9-i]};
            w[i]    = {{16{pair[i][12]}}, pair[i]};
        end
        exp_now = 29'(
            // 2020 = 2048 - 32 + 4
              (w[0] <<< 11) - (w[0] <<< 5) + (w[0] <<< 2)
            // 6589 = 8192 - 2048 + 512 - 64 - 4 + 1
            + (w[1] <<< 13) - (w[1] <<< 11) + (w[1] <<< 9)
            - (w[1] <<< 6)  - (w[1] <<< 2)  + w[1]
            // 15718 = 16384 - 512 - 128 - 32 + 8 - 2
            + (w[2] <<< 14) - (w[2] <<< 9)  - (w[2] <<< 7)
            - (w[2] <<< 5)  + (w[2] <<< 3)  - (w[2] <<< 1)
            // 25602 = 16384 + 8192 + 1024 + 2
            + (w[3] <<< 14) + (w[3] <<< 13) + (w[3] <<< 10) + (w[3] <<< 1)
            // 32768
            + (w[4] <<< 15));
    end

    // Align the expected value with Out_Y. The sum for sample t is ready
    // one cycle after t, and LATENCY-1 register stages carry it forward.
    generate
        if (LATENCY == 1) begin : g_no_dly
            assign exp_cmp = exp_now;
        end else begin : g_dly
            logic [28:0] dly [LATENCY-1];
            // Expected-value delay line, cleared so that nothing survives reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= exp_now;
                    for (int i = 1; i < LATENCY - 1; i++) dly[i] <= dly[i-1];
                end
            end
            assign exp_cmp = dly[LATENCY-2];
        end
    endgenerate

    // State and warm-up counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: enable low always parks the FSM in IDLE. WARMUP counts up
    // to WARM_LAST and then moves to CHECK.
    always_comb begin
        // NOTE: assign the defaults first so that no path leaves a variable
        // unassigned, which would infer a latch.
        state_d = state_q;
        wcnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WARMUP;
            end
            WARMUP: begin
                if (!enable)                  state_d = IDLE;
                else if (wcnt_q == WARM_LAST) state_d = CHECK;
                else                          wcnt_d  = wcnt_q + 7'd1;
            end
            CHECK: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign do_cmp  = (state_q == CHECK) && enable;
    assign differs = (Out_Y != exp_cmp);

    // Comparison results: mismatch pulse, saturating counters, first-failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch    <= 1'b0;
            err_count   <= '0;
            chk_count   <= '0;
            first_exp   <= '0;
            first_got   <= '0;
            first_valid <= 1'b0;
        end else begin
            mismatch <= do_cmp && differs;
            if (do_cmp && (chk_count != 16'hFFFF)) chk_count <= chk_count + 16'd1;
            if (do_cmp && differs) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!first_valid) begin
                    first_exp   <= exp_cmp;
                    first_got   <= Out_Y;
                    first_valid <= 1'b1;
                end
            end
        end
    end

endmodule
